// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the writeback arbiter
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DATA_W     = 32;

  // One buffered writeback: destination register plus result
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // One-hot decode of a register address; x0 never maps to a bit
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (a != '0) v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small synchronous FIFO holding late results that lost arbitration
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry one extra MSB so full and empty are distinguishable
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; reset discards any buffered entries at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage array; contents are meaningless while the pointers say empty
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges ALU and multi-cycle writebacks onto the register file write port
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int n     = 32,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  aluValid,
  input  logic [REG_ADDR_W-1:0] aluAdd,
  input  logic [n-1:0]          aluData,
  input  logic                  lateValid,
  input  logic [REG_ADDR_W-1:0] lateAdd,
  input  logic [n-1:0]          lateData,
  output logic                  lateReady,
  input  logic                  issueValid,
  input  logic [REG_ADDR_W-1:0] issueAdd,
  input  logic [REG_ADDR_W-1:0] readAdd1,
  input  logic [REG_ADDR_W-1:0] readAdd2,
  output logic                  stall,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] writeAdd,
  output logic [n-1:0]          writeData,
  output logic [NUM_REGS-1:0]   pendingMask
);

  localparam int ENTRY_W = REG_ADDR_W + n;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [ENTRY_W-1:0]    w_head;
  logic                  w_late_xfer;
  logic                  w_bypass;
  logic                  w_sel_valid;
  logic                  w_sel_late;
  logic [REG_ADDR_W-1:0] w_sel_addr;
  logic [n-1:0]          w_sel_data;
  logic [NUM_REGS-1:0]   w_set;
  logic [NUM_REGS-1:0]   w_clr;

  logic                  r_reg_write;
  logic [REG_ADDR_W-1:0] r_write_add;
  logic [n-1:0]          r_write_data;
  logic [NUM_REGS-1:0]   r_pend;

  assign lateReady   = !w_full;
  assign w_late_xfer = lateValid && lateReady;
  // A late result goes straight to the port only when nothing older or ALU-side competes
  assign w_bypass    = w_late_xfer && w_empty && !aluValid;
  assign w_push      = w_late_xfer && !w_bypass;
  assign w_pop       = !aluValid && !w_empty;

  wb_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data ({lateAdd, lateData}),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head)
  );

  // Pick the single source driving the write port this edge: ALU, then buffer head, then bypass
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_late  = 1'b0;
    w_sel_addr  = '0;
    w_sel_data  = '0;
    if (aluValid) begin
      w_sel_valid = 1'b1;
      w_sel_addr  = aluAdd;
      w_sel_data  = aluData;
    end else if (!w_empty) begin
      w_sel_valid = 1'b1;
      w_sel_late  = 1'b1;
      w_sel_addr  = w_head[ENTRY_W-1:n];
      w_sel_data  = w_head[n-1:0];
    end else if (w_bypass) begin
      w_sel_valid = 1'b1;
      w_sel_late  = 1'b1;
      w_sel_addr  = lateAdd;
      w_sel_data  = lateData;
    end
  end

  // Scoreboard set/clear vectors; x0 is excluded by the decode helper
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (issueValid) w_set = reg_onehot(issueAdd);
    if (w_sel_valid && w_sel_late) w_clr = reg_onehot(w_sel_addr);
  end

  // Registered write port; writes to x0 are swallowed with the enable low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_write  <= 1'b0;
      r_write_add  <= '0;
      r_write_data <= '0;
    end else begin
      r_reg_write <= w_sel_valid && (w_sel_addr != '0);
      if (w_sel_valid) begin
        r_write_add  <= w_sel_addr;
        r_write_data <= w_sel_data;
      end
    end
  end

  // Pending-write scoreboard; a new issue beats a same-edge completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_set;
    end
  end

  assign regWrite    = r_reg_write;
  assign writeAdd    = r_write_add;
  assign writeData   = r_write_data;
  assign pendingMask = r_pend;
  assign stall       = r_pend[readAdd1] | r_pend[readAdd2];

endmodule
